// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared FSM state and access-width encodings for the memory port arbiter
package mem_port_arbiter_pkg;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_BUSY_IF = 2'd1;
  localparam state_t ST_BUSY_DM = 2'd2;
  localparam state_t ST_RESP    = 2'd3;
  localparam logic [1:0] W_BYTE = 2'd0;
  localparam logic [1:0] W_HALF = 2'd1;
  localparam logic [1:0] W_WORD = 2'd2;
endpackage

// File: rtl/mem_strobe_gen.sv
// mem_strobe_gen: byte strobes and lane-shifted store data from access width and address offset
module mem_strobe_gen
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0]  width_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o
);
  always_comb begin
    wstrb_o = (width_i == W_BYTE) ? (4'b0001 << off_i) :
              (width_i == W_HALF) ? (4'b0011 << off_i) : 4'b1111;
    wdata_o = wdata_i << {off_i, 3'b000};
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus between fetch and data access, DM first with an IF starvation guard
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STREAK_MAX = 4,
  parameter int STREAK_W   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ready_o,
  output logic        if_rvalid_ro,
  output logic [31:0] if_rdata_ro,
  input  logic        dm_req_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  input  logic        dm_write_i,
  input  logic [1:0]  dm_width_i,
  output logic        dm_ready_o,
  output logic        dm_rvalid_ro,
  output logic [31:0] dm_rdata_ro,
  output logic        mem_req_ro,
  output logic [31:0] mem_addr_ro,
  output logic        mem_write_ro,
  output logic [3:0]  mem_wstrb_ro,
  output logic [31:0] mem_wdata_ro,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);
  localparam logic [STREAK_W-1:0] SMAX = STREAK_W'(STREAK_MAX);
  state_t              state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                kill_q, kill_d;
  logic                mem_req_q, mem_req_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic                mem_write_q, mem_write_d;
  logic [3:0]          mem_wstrb_q, mem_wstrb_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic                dm_rvalid_q, dm_rvalid_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic [31:0]         dm_rdata_q, dm_rdata_d;
  logic                idle, at_max, if_gnt, dm_gnt, ack;
  logic [3:0]          sg_wstrb;
  logic [31:0]         sg_wdata;
  logic                unused_if_lsb;
  assign unused_if_lsb = ^if_addr_i[1:0];
  mem_strobe_gen u_strobe (
    .width_i (dm_width_i),
    .off_i   (dm_addr_i[1:0]),
    .wdata_i (dm_wdata_i),
    .wstrb_o (sg_wstrb),
    .wdata_o (sg_wdata)
  );
  always_comb begin
    idle        = state_q == ST_IDLE;
    at_max      = streak_q == SMAX;
    dm_ready_o  = idle & ~(if_req_i & ~flush_i & at_max);
    if_ready_o  = idle & ~flush_i & (~dm_req_i | at_max);
    dm_gnt      = dm_req_i & dm_ready_o;
    if_gnt      = if_req_i & if_ready_o & ~dm_gnt;
    ack         = mem_req_q & mem_ack_i;
    state_d     = dm_gnt ? ST_BUSY_DM : if_gnt ? ST_BUSY_IF : ack ? ST_RESP :
                  (state_q == ST_RESP) ? ST_IDLE : state_q;
    // streak only counts DM wins that actually made a waiting fetch wait
    streak_d    = (~if_req_i | if_gnt) ? '0 : (dm_gnt & ~at_max) ? streak_q + 1'b1 : streak_q;
    kill_d      = ((state_q == ST_BUSY_IF) && flush_i) ? 1'b1 : (state_q == ST_RESP) ? 1'b0 : kill_q;
    mem_req_d   = dm_gnt | if_gnt | (mem_req_q & ~mem_ack_i);
    mem_addr_d  = dm_gnt ? {dm_addr_i[31:2], 2'b00} : if_gnt ? {if_addr_i[31:2], 2'b00} : mem_addr_q;
    mem_write_d = dm_gnt ? dm_write_i : if_gnt ? 1'b0 : mem_write_q;
    mem_wstrb_d = dm_gnt ? (dm_write_i ? sg_wstrb : 4'b0000) : if_gnt ? 4'b0000 : mem_wstrb_q;
    mem_wdata_d = dm_gnt ? sg_wdata : mem_wdata_q;
    // a flush landing in the ack cycle must suppress the response too
    if_rvalid_d = ack & (state_q == ST_BUSY_IF) & ~kill_q & ~flush_i;
    dm_rvalid_d = ack & (state_q == ST_BUSY_DM);
    if_rdata_d  = if_rvalid_d ? mem_rdata_i : if_rdata_q;
    dm_rdata_d  = dm_rvalid_d ? mem_rdata_i : dm_rdata_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      streak_q    <= '0;
      kill_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_write_q <= 1'b0;
      mem_wstrb_q <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      kill_q      <= kill_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_write_q <= mem_write_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end
  assign mem_req_ro   = mem_req_q;
  assign mem_addr_ro  = mem_addr_q;
  assign mem_write_ro = mem_write_q;
  assign mem_wstrb_ro = mem_wstrb_q;
  assign mem_wdata_ro = mem_wdata_q;
  assign if_rvalid_ro = if_rvalid_q;
  assign dm_rvalid_ro = dm_rvalid_q;
  assign if_rdata_ro  = if_rdata_q;
  assign dm_rdata_ro  = dm_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of the memory port arbiter against a transaction-level model
module tb_mem_port_arbiter;
  localparam int SMAX = 4;
  logic        clk = 1'b0, rst = 1'b1, flush_i = 1'b0;
  logic        if_req_i = 1'b0, dm_req_i = 1'b0, dm_write_i = 1'b0, mem_ack_i = 1'b0;
  logic [31:0] if_addr_i = '0, dm_addr_i = '0, dm_wdata_i = '0, mem_rdata_i = '0;
  logic [1:0]  dm_width_i = '0;
  logic        if_ready_o, if_rvalid_ro, dm_ready_o, dm_rvalid_ro, mem_req_ro, mem_write_ro;
  logic [31:0] if_rdata_ro, dm_rdata_ro, mem_addr_ro, mem_wdata_ro;
  logic [3:0]  mem_wstrb_ro;
  int          checks = 0, errors = 0;
  int          m_streak = 0, cur_g = 0;
  logic [31:0] m_if_rdata = '0, m_dm_rdata = '0;
  logic        obs_req;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_wstrb;

  mem_port_arbiter #(.STREAK_MAX(SMAX), .STREAK_W(3)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ready_o(if_ready_o),
    .if_rvalid_ro(if_rvalid_ro), .if_rdata_ro(if_rdata_ro),
    .dm_req_i(dm_req_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_write_i(dm_write_i), .dm_width_i(dm_width_i), .dm_ready_o(dm_ready_o),
    .dm_rvalid_ro(dm_rvalid_ro), .dm_rdata_ro(dm_rdata_ro),
    .mem_req_ro(mem_req_ro), .mem_addr_ro(mem_addr_ro), .mem_write_ro(mem_write_ro),
    .mem_wstrb_ro(mem_wstrb_ro), .mem_wdata_ro(mem_wdata_ro),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic chk1(input string tag, input logic o, input logic e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  // bytes covered by the access, clipped to the 4-byte word
  function automatic logic [3:0] exp_strb(input logic [1:0] w, input logic [1:0] a);
    int n;
    logic [3:0] s;
    s = 4'h0;
    if (w >= 2'd2) return 4'hF;
    n = (w == 2'd0) ? 1 : 2;
    for (int b = 0; b < 4; b++) if (b >= int'(a) && b < int'(a) + n) s[b] = 1'b1;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst || !if_req_i || cur_g == 1) m_streak = 0;
    else if (cur_g == 2 && m_streak < SMAX) m_streak++;
    cur_g = 0;
    @(negedge clk);
  endtask

  // one arbitration opportunity from IDLE, then the whole bus transaction if granted
  task automatic round(input logic ri, input logic rd, input logic [31:0] ia, input logic [31:0] da,
                       input logic [31:0] dd, input logic dw, input logic [1:0] dwid, input logic fl0,
                       input int dly, input int fl_at, input logic [31:0] rdat);
    int g;
    logic ex_if, ex_dm, killed, wr;
    logic [31:0] ea, ewd;
    logic [3:0] es;
    if_req_i = ri; dm_req_i = rd; if_addr_i = ia; dm_addr_i = da; dm_wdata_i = dd;
    dm_write_i = dw; dm_width_i = dwid; flush_i = fl0; mem_ack_i = 1'b0;
    #1;
    ex_if = !fl0 && (!rd || m_streak == SMAX);
    ex_dm = !(ri && !fl0 && m_streak == SMAX);
    chk1("if_ready_idle", if_ready_o, ex_if);
    chk1("dm_ready_idle", dm_ready_o, ex_dm);
    g = (rd && ex_dm) ? 2 : (ri && ex_if) ? 1 : 0;
    cur_g = g;
    tick();
    obs_req = mem_req_ro; obs_addr = mem_addr_ro; obs_wstrb = mem_wstrb_ro; obs_wdata = mem_wdata_ro;
    chk1("mem_req_after_accept", mem_req_ro, g != 0);
    if (g == 0) return;
    wr = (g == 2) && dw;
    ea = ((g == 2) ? da : ia) & ~32'h3;
    es = wr ? exp_strb(dwid, da[1:0]) : 4'h0;
    ewd = dd << (8 * int'(da[1:0]));
    killed = 1'b0;
    for (int k = 0; k <= dly; k++) begin
      if_req_i = (g == 1) ? 1'b0 : ri;
      dm_req_i = 1'b0;
      flush_i = (k == fl_at);
      mem_ack_i = (k == dly);
      mem_rdata_i = (k == dly) ? rdat : $urandom;
      #1;
      chk1("busy_mem_req", mem_req_ro, 1'b1);
      chk("busy_mem_addr", mem_addr_ro, ea);
      chk1("busy_mem_write", mem_write_ro, wr);
      chk("busy_mem_wstrb", {28'b0, mem_wstrb_ro}, {28'b0, es});
      if (wr) chk("busy_mem_wdata", mem_wdata_ro, ewd);
      chk1("busy_if_ready", if_ready_o, 1'b0);
      chk1("busy_dm_ready", dm_ready_o, 1'b0);
      if (g == 1 && flush_i) killed = 1'b1;
      tick();
    end
    mem_ack_i = 1'b0; flush_i = 1'b0;
    #1;
    if (g == 1 && !killed) m_if_rdata = rdat;
    if (g == 2) m_dm_rdata = rdat;
    chk1("resp_mem_req", mem_req_ro, 1'b0);
    chk1("resp_if_rvalid", if_rvalid_ro, g == 1 && !killed);
    chk1("resp_dm_rvalid", dm_rvalid_ro, g == 2);
    chk("resp_if_rdata", if_rdata_ro, m_if_rdata);
    chk("resp_dm_rdata", dm_rdata_ro, m_dm_rdata);
    chk1("resp_if_ready", if_ready_o, 1'b0);
    tick();
    chk1("post_if_rvalid", if_rvalid_ro, 1'b0);
    chk1("post_dm_rvalid", dm_rvalid_ro, 1'b0);
  endtask

  initial begin
    int dly, fat;
    @(negedge clk);
    chk1("rst_mem_req", mem_req_ro, 1'b0);
    chk("rst_mem_addr", mem_addr_ro, 32'h0);
    chk1("rst_if_rvalid", if_rvalid_ro, 1'b0);
    chk1("rst_dm_rvalid", dm_rvalid_ro, 1'b0);
    chk("rst_if_rdata", if_rdata_ro, 32'h0);
    rst = 1'b0;
    tick();
    round(1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 1'b0, 2'd2, 1'b0, 0, -1, 32'hDEADBEEF);
    chk("t1_addr", obs_addr, 32'h100);
    chk("t1_wstrb", {28'b0, obs_wstrb}, 32'h0);
    chk("t1_rdata", if_rdata_ro, 32'hDEADBEEF);
    for (int i = 0; i < 10; i++) begin
      round(1'b1, 1'b1, 32'h1000, 32'h2000, 32'h0, 1'b0, 2'd2, 1'b0, 0, -1, $urandom);
      chk("t2_grant_order", obs_addr, (i % 5 == 4) ? 32'h1000 : 32'h2000);
    end
    round(1'b0, 1'b1, 32'h0, 32'h203, 32'hA5, 1'b1, 2'd0, 1'b0, 1, -1, $urandom);
    chk("t3_sb_wstrb", {28'b0, obs_wstrb}, 32'h8);
    chk("t3_sb_wdata", obs_wdata, 32'hA5000000);
    chk("t3_sb_addr", obs_addr, 32'h200);
    round(1'b0, 1'b1, 32'h0, 32'h202, 32'h1234, 1'b1, 2'd1, 1'b0, 0, -1, $urandom);
    chk("t3_sh_wstrb", {28'b0, obs_wstrb}, 32'hC);
    chk("t3_sh_wdata", obs_wdata, 32'h12340000);
    round(1'b1, 1'b0, 32'h300, 32'h0, 32'h0, 1'b0, 2'd2, 1'b0, 3, 0, 32'h11112222);
    round(1'b1, 1'b0, 32'h304, 32'h0, 32'h0, 1'b0, 2'd2, 1'b0, 0, -1, 32'h33334444);
    chk1("t4_next_if_req", obs_req, 1'b1);
    chk("t4_next_if_addr", obs_addr, 32'h304);
    round(1'b0, 1'b1, 32'h0, 32'h4001, 32'hCAFEF00D, 1'b1, 2'd2, 1'b0, 10, -1, $urandom);
    chk("t6_addr", obs_addr, 32'h4000);
    chk("t6_wstrb", {28'b0, obs_wstrb}, 32'hF);
    for (int i = 0; i < 60; i++) begin
      dly = int'($urandom_range(0, 3));
      fat = int'($urandom_range(0, 3));
      if (fat > dly || $urandom_range(0, 1) == 0) fat = -1;
      round(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom, $urandom, $urandom,
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
            dly, fat, $urandom);
    end
    round(1'b1, 1'b0, 32'h500, 32'h0, 32'h0, 1'b0, 2'd2, 1'b0, 0, -1, 32'h0BADF00D);
    if_req_i = 1'b1; if_addr_i = 32'h400; dm_req_i = 1'b0; flush_i = 1'b0;
    #1;
    cur_g = 1;
    tick();
    if_req_i = 1'b0;
    #1;
    chk1("t5_pre_mem_req", mem_req_ro, 1'b1);
    rst = 1'b1;
    #1;
    m_streak = 0; m_if_rdata = '0; m_dm_rdata = '0;
    chk1("t5_async_mem_req", mem_req_ro, 1'b0);
    chk("t5_async_mem_addr", mem_addr_ro, 32'h0);
    chk("t5_async_if_rdata", if_rdata_ro, m_if_rdata);
    chk("t5_async_wdata", mem_wdata_ro, 32'h0);
    chk1("t5_async_write", mem_write_ro, 1'b0);
    tick();
    rst = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h55555555;
    #1;
    chk1("t5_idle_if_ready", if_ready_o, 1'b1);
    tick();
    mem_ack_i = 1'b0;
    chk1("t5_late_ack_if_rvalid", if_rvalid_ro, 1'b0);
    chk1("t5_late_ack_dm_rvalid", dm_rvalid_ro, 1'b0);
    chk1("t5_late_ack_mem_req", mem_req_ro, 1'b0);
    chk("t5_late_ack_if_rdata", if_rdata_ro, m_if_rdata);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
